// File: rtl/alarm_pkg.sv
// Shared constants and state encoding for the alarm controller.
package alarm_pkg;

   localparam int unsigned TIME_W        = 32;
   localparam int unsigned HOURS_MSB     = 31;
   localparam int unsigned MINUTES_LSB   = 16;
   localparam int unsigned MIN_ONES_MSB  = 19;
   localparam int unsigned MIN_ONES_LSB  = 16;
   localparam int unsigned DIGIT_W       = 4;
   localparam int unsigned MIN_CNT_W     = 4;
   localparam int unsigned BEEP_CNT_W    = 22;

   localparam logic [DIGIT_W-1:0] INVALID_DIGIT = 4'hF;

   typedef enum logic [1:0] {
      ST_DISARMED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_RINGING  = 2'd2,
      ST_SNOOZING = 2'd3
   } alarm_state_e;

endpackage

// File: rtl/alarm_beep_gen.sv
// Square-wave buzzer driver: starts high on ring entry, toggles every half period.
module alarm_beep_gen
   import alarm_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = 2500000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic start,
   output logic buzzer
);

   logic [BEEP_CNT_W-1:0] cnt_q;

   // Half-period counter and toggle; held cleared and silent while not enabled.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt_q  <= '0;
         buzzer <= 1'b0;
      end else if (start) begin
         cnt_q  <= '0;
         buzzer <= 1'b1;
      end else if (cnt_q == BEEP_CNT_W'(HALF_PERIOD - 1)) begin
         cnt_q  <= '0;
         buzzer <= ~buzzer;
      end else begin
         cnt_q  <= cnt_q + BEEP_CNT_W'(1);
      end
   end

endmodule

// File: rtl/alarm_controller.sv
// Alarm decision logic: HH:MM/PM match, minute ticks, button edges and the
// arm/ring/snooze/dismiss state machine driving the buzzer and indicators.
module alarm_controller
   import alarm_pkg::*;
#(
   parameter int unsigned BEEP_HALF_PERIOD = 2500000,
   parameter int unsigned SNOOZE_MINUTES   = 9,
   parameter int unsigned RING_MINUTES     = 5
) (
   input  logic              i_Clk_5MHz,
   input  logic              i_Reset,
   input  logic [TIME_W-1:0] i_Current_Time,
   input  logic              i_Current_PM,
   input  logic [TIME_W-1:0] i_Alarm_Time,
   input  logic              i_Alarm_PM,
   input  logic              i_Alarm_Enable,
   input  logic              i_Snooze,
   input  logic              i_Dismiss,
   output logic              o_Buzzer,
   output logic              o_Ringing,
   output logic              o_Snoozing,
   output logic              o_Armed
);

   alarm_state_e         state_q, state_d;
   logic [MIN_CNT_W-1:0] ring_cnt_q, ring_cnt_d;
   logic [MIN_CNT_W-1:0] snooze_cnt_q, snooze_cnt_d;
   logic                 match_q;
   logic [DIGIT_W-1:0]   min_q;
   logic                 snooze_btn_q;
   logic                 dismiss_btn_q;

   logic                 match;
   logic                 trigger;
   logic                 tick;
   logic                 snooze_rise;
   logic                 dismiss_rise;
   logic [DIGIT_W-1:0]   min_field;
   logic                 beep_en;
   logic                 beep_start;
   logic                 unused_time_bits;

   // Seconds and fractions never take part in the decision.
   assign unused_time_bits = ^{i_Current_Time[MINUTES_LSB-1:0], i_Alarm_Time[MINUTES_LSB-1:0]};

   // Match on HH:MM and meridiem; trigger only on the first matching cycle.
   assign match   = (i_Current_Time[HOURS_MSB:MINUTES_LSB] == i_Alarm_Time[HOURS_MSB:MINUTES_LSB])
                 && (i_Current_PM == i_Alarm_PM);
   assign trigger = match && !match_q;

   // A change of the minutes ones digit marks a minute rollover.
   assign min_field = i_Current_Time[MIN_ONES_MSB:MIN_ONES_LSB];
   assign tick      = (min_q != INVALID_DIGIT) && (min_field != min_q);

   assign snooze_rise  = i_Snooze && !snooze_btn_q;
   assign dismiss_rise = i_Dismiss && !dismiss_btn_q;

   // History registers for match, minute digit and button edge detection.
   always_ff @(posedge i_Clk_5MHz) begin
      if (i_Reset) begin
         match_q       <= 1'b0;
         min_q         <= INVALID_DIGIT;
         snooze_btn_q  <= 1'b0;
         dismiss_btn_q <= 1'b0;
      end else begin
         match_q       <= match;
         min_q         <= min_field;
         snooze_btn_q  <= i_Snooze;
         dismiss_btn_q <= i_Dismiss;
      end
   end

   // Next state and minute counters; disable overrides everything.
   always_comb begin
      state_d      = state_q;
      ring_cnt_d   = ring_cnt_q;
      snooze_cnt_d = snooze_cnt_q;
      if (!i_Alarm_Enable) begin
         state_d      = ST_DISARMED;
         ring_cnt_d   = '0;
         snooze_cnt_d = '0;
      end else begin
         case (state_q)
            ST_DISARMED: state_d = ST_ARMED;
            ST_ARMED: begin
               if (trigger) begin
                  state_d    = ST_RINGING;
                  ring_cnt_d = MIN_CNT_W'(RING_MINUTES);
               end
            end
            ST_RINGING: begin
               if (dismiss_rise) begin
                  state_d    = ST_ARMED;
                  ring_cnt_d = '0;
               end else if (snooze_rise) begin
                  state_d      = ST_SNOOZING;
                  ring_cnt_d   = '0;
                  snooze_cnt_d = MIN_CNT_W'(SNOOZE_MINUTES);
               end else if (tick) begin
                  if (ring_cnt_q <= MIN_CNT_W'(1)) begin
                     state_d    = ST_ARMED;
                     ring_cnt_d = '0;
                  end else begin
                     ring_cnt_d = ring_cnt_q - MIN_CNT_W'(1);
                  end
               end
            end
            ST_SNOOZING: begin
               if (dismiss_rise) begin
                  state_d      = ST_ARMED;
                  snooze_cnt_d = '0;
               end else if (tick) begin
                  if (snooze_cnt_q <= MIN_CNT_W'(1)) begin
                     state_d      = ST_RINGING;
                     snooze_cnt_d = '0;
                     ring_cnt_d   = MIN_CNT_W'(RING_MINUTES);
                  end else begin
                     snooze_cnt_d = snooze_cnt_q - MIN_CNT_W'(1);
                  end
               end
            end
            default: state_d = ST_DISARMED;
         endcase
      end
   end

   // State register with registered state indicators.
   always_ff @(posedge i_Clk_5MHz) begin
      if (i_Reset) begin
         state_q      <= ST_DISARMED;
         ring_cnt_q   <= '0;
         snooze_cnt_q <= '0;
         o_Ringing    <= 1'b0;
         o_Snoozing   <= 1'b0;
         o_Armed      <= 1'b0;
      end else begin
         state_q      <= state_d;
         ring_cnt_q   <= ring_cnt_d;
         snooze_cnt_q <= snooze_cnt_d;
         o_Ringing    <= (state_d == ST_RINGING);
         o_Snoozing   <= (state_d == ST_SNOOZING);
         o_Armed      <= (state_d == ST_ARMED);
      end
   end

   // Buzzer restarts high on every entry into RINGING, including from snooze.
   assign beep_en    = (state_d == ST_RINGING);
   assign beep_start = beep_en && (state_q != ST_RINGING);

   alarm_beep_gen #(
      .HALF_PERIOD (BEEP_HALF_PERIOD)
   ) u_beep_gen (
      .clk    (i_Clk_5MHz),
      .rst    (i_Reset),
      .en     (beep_en),
      .start  (beep_start),
      .buzzer (o_Buzzer)
   );

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller; expected outputs are queued per cycle
// and compared after the clock edge that should produce them.
module tb_alarm_controller;

   // Output vector order: {buzzer, ringing, snoozing, armed}
   localparam logic [3:0] O_OFF   = 4'b0000;
   localparam logic [3:0] O_ARM   = 4'b0001;
   localparam logic [3:0] O_SNZ   = 4'b0010;
   localparam logic [3:0] O_RING1 = 4'b1100;
   localparam logic [3:0] O_RING0 = 4'b0100;

   typedef struct {
      string      tag;
      logic [3:0] outs;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cur_time;
   logic        cur_pm;
   logic [31:0] alm_time;
   logic        alm_pm;
   logic        enable;
   logic        snooze;
   logic        dismiss;
   logic        buzzer;
   logic        ringing;
   logic        snoozing;
   logic        armed;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   alarm_controller #(
      .BEEP_HALF_PERIOD (4),
      .SNOOZE_MINUTES   (2),
      .RING_MINUTES     (3)
   ) dut (
      .i_Clk_5MHz     (clk),
      .i_Reset        (rst),
      .i_Current_Time (cur_time),
      .i_Current_PM   (cur_pm),
      .i_Alarm_Time   (alm_time),
      .i_Alarm_PM     (alm_pm),
      .i_Alarm_Enable (enable),
      .i_Snooze       (snooze),
      .i_Dismiss      (dismiss),
      .o_Buzzer       (buzzer),
      .o_Ringing      (ringing),
      .o_Snoozing     (snoozing),
      .o_Armed        (armed)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", tag, act, exp);
      end
   endtask

   // Queue the expected outputs, advance one clock, then score the oldest entry.
   task automatic step(input string tag, input logic [3:0] exp);
      exp_t e;
      exp_t got;
      e.tag  = tag;
      e.outs = exp;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      check(got.tag, 32'({buzzer, ringing, snoozing, armed}), 32'(got.outs));
   endtask

   initial begin
      rst      = 1'b1;
      enable   = 1'b0;
      snooze   = 1'b0;
      dismiss  = 1'b0;
      cur_time = 32'h0729_5999;
      cur_pm   = 1'b0;
      alm_time = 32'h0730_0000;
      alm_pm   = 1'b0;

      step("reset0", O_OFF);
      step("reset1", O_OFF);

      // Release reset and enable: arms on the first cycle.
      rst = 1'b0; enable = 1'b1;
      step("arm", O_ARM);
      step("arm_hold", O_ARM);

      // Minute reaches 07:30 AM: rings next cycle, buzzer 1,1,1,1,0,0,0,0,...
      cur_time = 32'h0730_0000;
      step("ring_entry", O_RING1);
      for (int k = 1; k < 12; k++)
         step($sformatf("beep_k%0d", k), ((k % 8) < 4) ? O_RING1 : O_RING0);

      // Dismiss, held for two cycles: single action, no retrigger.
      dismiss = 1'b1;
      step("dismiss", O_ARM);
      step("dismiss_hold", O_ARM);
      dismiss = 1'b0;

      // Same HH:MM but PM does not match an AM alarm.
      cur_time = 32'h0731_0000;
      step("move_0731", O_ARM);
      cur_time = 32'h0730_0000; cur_pm = 1'b1;
      step("pm_nomatch0", O_ARM);
      step("pm_nomatch1", O_ARM);

      // Enabling while already inside the matching minute must not ring.
      enable = 1'b0;
      step("disable", O_OFF);
      cur_pm = 1'b0;
      step("disabled_at_match", O_OFF);
      enable = 1'b1;
      step("enable_mid_match", O_ARM);
      step("enable_mid_match1", O_ARM);
      step("enable_mid_match2", O_ARM);

      // Ring, snooze, two rollovers then re-ring; re-press while snoozing ignored.
      cur_time = 32'h0729_5999;
      step("pre_match", O_ARM);
      cur_time = 32'h0730_0000;
      step("ring2", O_RING1);
      snooze = 1'b1;
      step("snooze", O_SNZ);
      snooze = 1'b0;
      step("snooze_rel", O_SNZ);
      cur_time = 32'h0731_0000;
      step("snz_tick1", O_SNZ);
      snooze = 1'b1;
      step("snz_repress", O_SNZ);
      snooze = 1'b0;
      step("snz_repress_rel", O_SNZ);
      cur_time = 32'h0732_0000;
      step("snz_tick2_rering", O_RING1);

      // Snooze and dismiss together: dismiss wins.
      snooze = 1'b1; dismiss = 1'b1;
      step("snz_dis_same", O_ARM);
      snooze = 1'b0; dismiss = 1'b0;
      step("snz_dis_rel", O_ARM);

      // Editing the alarm onto the current minute triggers; auto-stop after 3 rollovers.
      alm_time = 32'h0732_0000;
      step("edit_trigger", O_RING1);
      cur_time = 32'h0733_0000;
      step("ring_tick1", O_RING1);
      cur_time = 32'h0734_0000;
      step("ring_tick2", O_RING1);
      cur_time = 32'h0735_0000;
      step("ring_timeout", O_ARM);

      // Enable dropping while ringing clears all outputs next cycle.
      alm_time = 32'h0735_0000;
      step("ring4", O_RING1);
      enable = 1'b0;
      step("ring_disable", O_OFF);
      enable = 1'b1;
      step("reenable", O_ARM);
      step("reenable_hold", O_ARM);

      // Reset in SNOOZING returns to DISARMED with no residual counts.
      cur_time = 32'h0736_0000;
      step("pre5", O_ARM);
      alm_time = 32'h0736_0000;
      step("ring5", O_RING1);
      snooze = 1'b1;
      step("snooze5", O_SNZ);
      snooze = 1'b0;
      step("snooze5_rel", O_SNZ);
      rst = 1'b1;
      step("reset_mid_snooze", O_OFF);
      rst = 1'b0;
      step("post_reset_arm", O_ARM);
      step("post_reset_hold", O_ARM);

      cur_time = 32'h0737_0000;
      step("pre6", O_ARM);
      alm_time = 32'h0737_0000;
      step("ring6", O_RING1);
      cur_time = 32'h0738_0000;
      step("ring6_tick1", O_RING1);
      cur_time = 32'h0739_0000;
      step("ring6_tick2", O_RING1);
      cur_time = 32'h0740_0000;
      step("ring6_timeout", O_ARM);

      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Consumes the packed 12-hour BCD time words from the running clock and the alarm-time setter, and decides when the alarm sounds. The block detects an HH:MM/PM match and runs the arm/ring/snooze/dismiss state machine. It derives minute ticks from the clock's minutes digit and drives a pulsed buzzer output. It sits between the two time-word producers and the buzzer pin/LEDs on the 5 MHz domain.

## Interface
- BEEP_HALF_PERIOD, 2500000: clock cycles per buzzer half-period (0.5 s at 5 MHz); counter width 22 bits.
- SNOOZE_MINUTES, 9: minute rollovers spent in SNOOZING before re-ringing; 1..15.
- RING_MINUTES, 5: minute rollovers in RINGING before auto-return to ARMED; 1..15.
- i_Clk_5MHz  in  1  sole clock, rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Current_Time  in  32  packed BCD {Hh,Hl,Mh,Ml,Sh,Sl,Fh,Fl}, 4 bits each, hours 01..12.
- i_Current_PM  in  1  current time is PM.
- i_Alarm_Time  in  32  same packing, alarm setting.
- i_Alarm_PM  in  1  alarm is PM.
- i_Alarm_Enable  in  1  level; low forces DISARMED.
- i_Snooze  in  1  debounced button level; acted on at rising edge.
- i_Dismiss  in  1  debounced button level; acted on at rising edge.
- o_Buzzer  out  1  square wave while RINGING, else 0.
- o_Ringing, o_Snoozing, o_Armed  out  1 each  state indicators (o_Armed high in ARMED only).

## Operation
- Match = (i_Current_Time[31:16] == i_Alarm_Time[31:16]) && (i_Current_PM == i_Alarm_PM); seconds/fraction ignored.
- match_q registers Match every cycle in every state; trigger = Match && !match_q.
- Minute tick: min_q registers i_Current_Time[19:16]; tick = (min_q != 4'hF) && (field != min_q). min_q resets to 4'hF, so no tick in the first cycle after reset.
- States: DISARMED, ARMED, RINGING, SNOOZING. Priority, highest first:
  - !i_Alarm_Enable -> DISARMED from any state.
  - DISARMED -> ARMED when enabled. Enabling mid-match minute does not ring; the edge has already passed.
  - ARMED -> RINGING on trigger. Ring counter loads RING_MINUTES.
  - RINGING: dismiss edge -> ARMED. Otherwise snooze edge -> SNOOZING, snooze counter loads SNOOZE_MINUTES. Otherwise tick decrements ring counter; reaching 0 -> ARMED.
  - SNOOZING: dismiss edge -> ARMED. Otherwise tick decrements snooze counter; reaching 0 -> RINGING, ring counter reloads RING_MINUTES. Snooze edges and triggers are ignored.
- Simultaneous events: dismiss beats snooze; snooze beats tick/timeout in the same cycle, and the tick is discarded.
- A trigger caused by editing the alarm time onto the current minute rings like any other trigger.
- Buzzer: on RINGING entry, o_Buzzer=1 and the beep counter clears. It toggles every BEEP_HALF_PERIOD cycles. Forced 0 and counter cleared outside RINGING.
- Snooze/ring durations are counted in rollovers: actual time is between N-1 and N minutes.

## Timing
- Reset: state DISARMED; all outputs 0; match_q=0; min_q=4'hF; button edge registers 0; counters 0.
- Trigger seen in cycle N -> o_Ringing and o_Buzzer high in cycle N+1.
- Button rising in cycle N -> state outputs change in cycle N+1. Holding a button causes one action only.
- i_Alarm_Enable low in cycle N -> all outputs 0 in cycle N+1.
- Reset mid-RINGING/SNOOZING -> DISARMED next cycle, no residual count.
- Counter wrap: decrementing from 1 transitions; the counter never underflows.

## Structure
- Package alarm_pkg: state enum (2 bits); field slice constants HOURS_MSB=31, MINUTES_LSB=16, MIN_ONES_MSB=19, MIN_ONES_LSB=16; INVALID_DIGIT=4'hF.
- One sub-module, alarm_beep_gen: enable, half-period counter, toggle output. Match, tick, edge detect and FSM stay in the top.
- Target roughly 180-250 RTL lines.

## Test plan
- Sim params BEEP_HALF_PERIOD=4, SNOOZE_MINUTES=2, RING_MINUTES=3.
- Enabled, alarm 32'h0730_0000 AM; current steps 32'h0729_5999 -> 32'h0730_0000 AM -> o_Ringing next cycle; o_Buzzer 1,1,1,1,0,0,0,0 repeating.
- Same alarm with current 07:30 PM -> no ring. Enable asserted while already at 07:30 AM -> stays ARMED, no ring.
- Ringing, snooze press -> o_Snoozing. Minutes digit advances 0->1->2 -> o_Ringing after the second change. Snooze re-press while snoozing -> no effect.
- Ringing, snooze and dismiss in the same cycle -> ARMED, o_Buzzer 0. Ringing untouched through 3 minute rollovers -> ARMED after the third.
- Ringing, i_Alarm_Enable drops -> all outputs 0 next cycle. i_Reset mid-SNOOZING -> DISARMED. No spurious tick on the first post-reset cycle.
